// File: rtl/exe_stage_md.sv
// exe_stage_md: pipelined execute stage with its EX/MEM output register.
//   Single-cycle logic/shift/move/arith ops, MULT/MULTU with HI/LO write-back, an iterative
//   restoring divider (DIV/DIVU) that stalls upstream, and signed ADD/SUB overflow detection.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   flush                kills the in-flight op (highest priority)
//   in_valid             operands / control below are valid
//   src1, src2           operands (src2 already immediate-extended)
//   aluop, alusel        operation code and result-class select
//   waddr, reg_write_in  destination register and GPR write enable
//   hi_in, lo_in         current HI/LO values
//   stall_req            divider (or accumulate) busy, upstream must hold
//   out_valid ... ov_exc registered EX/MEM results
// Optional feature: define EXE_MADD_EN to support MADD/MADDU/MSUB/MSUBU (two-cycle
//   multiply-accumulate into HI/LO). Without it those opcodes decode as unknown.
module exe_stage_md #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 8,
   parameter int unsigned SEL_W  = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   input  logic [OP_W-1:0]   aluop,
   input  logic [SEL_W-1:0]  alusel,
   input  logic [4:0]        waddr,
   input  logic              reg_write_in,
   input  logic [DATA_W-1:0] hi_in,
   input  logic [DATA_W-1:0] lo_in,
   output logic              stall_req,
   output logic              out_valid,
   output logic [DATA_W-1:0] alu_result,
   output logic [4:0]        write_reg,
   output logic              reg_write_out,
   output logic [DATA_W-1:0] hi_out,
   output logic [DATA_W-1:0] lo_out,
   output logic              whilo_out,
   output logic              ov_exc
);

   localparam int unsigned ShW = $clog2(DATA_W);

   localparam logic [OP_W-1:0] ExeAndOp   = OP_W'(8'h24);
   localparam logic [OP_W-1:0] ExeOrOp    = OP_W'(8'h25);
   localparam logic [OP_W-1:0] ExeXorOp   = OP_W'(8'h26);
   localparam logic [OP_W-1:0] ExeNorOp   = OP_W'(8'h27);
   localparam logic [OP_W-1:0] ExeSllOp   = OP_W'(8'h7C);
   localparam logic [OP_W-1:0] ExeSllvOp  = OP_W'(8'h04);
   localparam logic [OP_W-1:0] ExeSrlOp   = OP_W'(8'h02);
   localparam logic [OP_W-1:0] ExeSrlvOp  = OP_W'(8'h06);
   localparam logic [OP_W-1:0] ExeSraOp   = OP_W'(8'h03);
   localparam logic [OP_W-1:0] ExeSravOp  = OP_W'(8'h07);
   localparam logic [OP_W-1:0] ExeMfhiOp  = OP_W'(8'h10);
   localparam logic [OP_W-1:0] ExeMthiOp  = OP_W'(8'h11);
   localparam logic [OP_W-1:0] ExeMfloOp  = OP_W'(8'h12);
   localparam logic [OP_W-1:0] ExeMtloOp  = OP_W'(8'h13);
   localparam logic [OP_W-1:0] ExeSltOp   = OP_W'(8'h2A);
   localparam logic [OP_W-1:0] ExeSltuOp  = OP_W'(8'h2B);
   localparam logic [OP_W-1:0] ExeAddOp   = OP_W'(8'h20);
   localparam logic [OP_W-1:0] ExeAdduOp  = OP_W'(8'h21);
   localparam logic [OP_W-1:0] ExeSubOp   = OP_W'(8'h22);
   localparam logic [OP_W-1:0] ExeSubuOp  = OP_W'(8'h23);
   localparam logic [OP_W-1:0] ExeAddiOp  = OP_W'(8'h55);
   localparam logic [OP_W-1:0] ExeAddiuOp = OP_W'(8'h56);
   localparam logic [OP_W-1:0] ExeMultOp  = OP_W'(8'h18);
   localparam logic [OP_W-1:0] ExeMultuOp = OP_W'(8'h19);
   localparam logic [OP_W-1:0] ExeDivOp   = OP_W'(8'h1A);
   localparam logic [OP_W-1:0] ExeDivuOp  = OP_W'(8'h1B);
`ifdef EXE_MADD_EN
   localparam logic [OP_W-1:0] ExeMaddOp  = OP_W'(8'hA6);
   localparam logic [OP_W-1:0] ExeMadduOp = OP_W'(8'hA8);
   localparam logic [OP_W-1:0] ExeMsubOp  = OP_W'(8'hAA);
   localparam logic [OP_W-1:0] ExeMsubuOp = OP_W'(8'hAB);
`endif

   localparam logic [SEL_W-1:0] ResLogic = SEL_W'(3'b001);
   localparam logic [SEL_W-1:0] ResShift = SEL_W'(3'b010);
   localparam logic [SEL_W-1:0] ResMove  = SEL_W'(3'b011);
   localparam logic [SEL_W-1:0] ResArith = SEL_W'(3'b100);

   typedef enum logic [1:0] {
      StIdle,
      StDiv,
`ifdef EXE_MADD_EN
      StMacc,
`endif
      StDone
   } state_e;

   // ---------------------------------------------------------------- single-cycle datapath
   logic [DATA_W-1:0]   sum, diff;
   logic [ShW-1:0]      sa;
   logic                lt_s, lt_u;
   logic                mul_signed;
   logic [2*DATA_W-1:0] mul_a, mul_b, prod;
   logic [DATA_W-1:0]   logic_res, shift_res, move_res, arith_res, alu_res;
   logic [DATA_W-1:0]   hi_res, lo_res;
   logic                whilo_res, ov;

   assign sum  = src1 + src2;
   assign diff = src1 - src2;
   assign sa   = src1[ShW-1:0];
   assign lt_s = $signed(src1) < $signed(src2);
   assign lt_u = src1 < src2;

`ifdef EXE_MADD_EN
   assign mul_signed = (aluop == ExeMultOp) || (aluop == ExeMaddOp) || (aluop == ExeMsubOp);
`else
   assign mul_signed = (aluop == ExeMultOp);
`endif
   // Sign/zero-extending to 2*DATA_W makes one unsigned multiplier serve both flavours.
   assign mul_a = mul_signed ? {{DATA_W{src1[DATA_W-1]}}, src1} : {{DATA_W{1'b0}}, src1};
   assign mul_b = mul_signed ? {{DATA_W{src2[DATA_W-1]}}, src2} : {{DATA_W{1'b0}}, src2};
   assign prod  = mul_a * mul_b;

   always_comb begin
      logic_res = '0;
      shift_res = '0;
      move_res  = '0;
      arith_res = '0;
      hi_res    = hi_in;
      lo_res    = lo_in;
      whilo_res = 1'b0;
      ov        = 1'b0;
      case (aluop)
         ExeAndOp:              logic_res = src1 & src2;
         ExeOrOp:               logic_res = src1 | src2;
         ExeXorOp:              logic_res = src1 ^ src2;
         ExeNorOp:              logic_res = ~(src1 | src2);
         ExeSllOp, ExeSllvOp:   shift_res = src2 << sa;
         ExeSrlOp, ExeSrlvOp:   shift_res = src2 >> sa;
         ExeSraOp, ExeSravOp:   shift_res = $unsigned($signed(src2) >>> sa);
         ExeMfhiOp:             move_res  = hi_in;
         ExeMfloOp:             move_res  = lo_in;
         ExeMthiOp: begin
            hi_res    = src1;
            whilo_res = 1'b1;
         end
         ExeMtloOp: begin
            lo_res    = src1;
            whilo_res = 1'b1;
         end
         ExeAddOp, ExeAddiOp: begin
            arith_res = sum;
            ov = (src1[DATA_W-1] == src2[DATA_W-1]) && (sum[DATA_W-1] != src1[DATA_W-1]);
         end
         ExeAdduOp, ExeAddiuOp: arith_res = sum;
         ExeSubOp: begin
            arith_res = diff;
            ov = (src1[DATA_W-1] != src2[DATA_W-1]) && (diff[DATA_W-1] != src1[DATA_W-1]);
         end
         ExeSubuOp:             arith_res = diff;
         ExeSltOp:              arith_res = {{(DATA_W-1){1'b0}}, lt_s};
         ExeSltuOp:             arith_res = {{(DATA_W-1){1'b0}}, lt_u};
         ExeMultOp, ExeMultuOp: begin
            hi_res    = prod[2*DATA_W-1:DATA_W];
            lo_res    = prod[DATA_W-1:0];
            whilo_res = 1'b1;
         end
         // Only reaches the outputs for a zero divisor; nonzero divisors go to the FSM.
         ExeDivOp, ExeDivuOp: begin
            hi_res    = src1;
            lo_res    = '1;
            whilo_res = 1'b1;
         end
         default: ;
      endcase
      case (alusel)
         ResLogic: alu_res = logic_res;
         ResShift: alu_res = shift_res;
         ResMove:  alu_res = move_res;
         ResArith: alu_res = arith_res;
         default:  alu_res = '0;
      endcase
   end

   // ---------------------------------------------------------------- divider operand prep
   logic              is_div, div_signed, a_neg, b_neg;
   logic [DATA_W-1:0] a_mag, b_mag;

   assign is_div     = (aluop == ExeDivOp) || (aluop == ExeDivuOp);
   assign div_signed = (aluop == ExeDivOp);
   assign a_neg      = div_signed & src1[DATA_W-1];
   assign b_neg      = div_signed & src2[DATA_W-1];
   assign a_mag      = a_neg ? -src1 : src1;
   assign b_mag      = b_neg ? -src2 : src2;

`ifdef EXE_MADD_EN
   logic                is_madd, madd_sub;
   logic [2*DATA_W-1:0] prod_q, prod_d, acc;
   logic                msub_q, msub_d;
   assign is_madd  = (aluop == ExeMaddOp) || (aluop == ExeMadduOp) ||
                     (aluop == ExeMsubOp) || (aluop == ExeMsubuOp);
   assign madd_sub = (aluop == ExeMsubOp) || (aluop == ExeMsubuOp);
   // hi_in/lo_in are still held by upstream during the accumulate cycle.
   assign acc = msub_q ? ({hi_in, lo_in} - prod_q) : ({hi_in, lo_in} + prod_q);
`endif

   // ---------------------------------------------------------------- state
   state_e            state_q, state_d;
   logic [ShW-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
   logic              neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
   logic [4:0]        div_waddr_q, div_waddr_d;
   logic              div_rw_q, div_rw_d;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] alu_result_q, alu_result_d;
   logic [4:0]        write_reg_q, write_reg_d;
   logic              reg_write_q, reg_write_d;
   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
   logic              whilo_q, whilo_d;
   logic              ov_q, ov_d;
   logic              stall_c;

   // One restoring step: shift in the next dividend bit (quot_q MSB) and try to subtract.
   logic [DATA_W:0] div_shift, div_trial;
   assign div_shift = {rem_q, quot_q[DATA_W-1]};
   assign div_trial = div_shift - {1'b0, dvsr_q};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rem_d        = rem_q;
      quot_d       = quot_q;
      dvsr_d       = dvsr_q;
      neg_quot_d   = neg_quot_q;
      neg_rem_d    = neg_rem_q;
      div_waddr_d  = div_waddr_q;
      div_rw_d     = div_rw_q;
`ifdef EXE_MADD_EN
      prod_d       = prod_q;
      msub_d       = msub_q;
`endif
      stall_c      = 1'b0;
      out_valid_d  = 1'b0;
      reg_write_d  = 1'b0;
      whilo_d      = 1'b0;
      ov_d         = 1'b0;
      alu_result_d = alu_result_q;
      write_reg_d  = write_reg_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      if (flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  if (is_div && (src2 != '0)) begin
                     stall_c     = 1'b1;
                     state_d     = StDiv;
                     cnt_d       = ShW'(DATA_W - 1);
                     rem_d       = '0;
                     quot_d      = a_mag;
                     dvsr_d      = b_mag;
                     neg_quot_d  = a_neg ^ b_neg;
                     neg_rem_d   = a_neg;
                     div_waddr_d = waddr;
                     div_rw_d    = reg_write_in;
`ifdef EXE_MADD_EN
                  end else if (is_madd) begin
                     stall_c = 1'b1;
                     prod_d  = prod;
                     msub_d  = madd_sub;
                     state_d = StMacc;
`endif
                  end else begin
                     out_valid_d  = 1'b1;
                     alu_result_d = alu_res;
                     write_reg_d  = waddr;
                     reg_write_d  = reg_write_in & ~ov;
                     hi_d         = hi_res;
                     lo_d         = lo_res;
                     whilo_d      = whilo_res;
                     ov_d         = ov;
                  end
               end
            end
            StDiv: begin
               stall_c = 1'b1;
               if (!div_trial[DATA_W]) begin
                  rem_d  = div_trial[DATA_W-1:0];
                  quot_d = {quot_q[DATA_W-2:0], 1'b1};
               end else begin
                  rem_d  = div_shift[DATA_W-1:0];
                  quot_d = {quot_q[DATA_W-2:0], 1'b0};
               end
               if (cnt_q == '0) begin
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            StDone: begin
               state_d      = StIdle;
               out_valid_d  = 1'b1;
               alu_result_d = '0;
               write_reg_d  = div_waddr_q;
               reg_write_d  = div_rw_q;
               hi_d         = neg_rem_q ? -rem_q : rem_q;
               lo_d         = neg_quot_q ? -quot_q : quot_q;
               whilo_d      = 1'b1;
            end
`ifdef EXE_MADD_EN
            StMacc: begin
               state_d      = StIdle;
               out_valid_d  = 1'b1;
               alu_result_d = '0;
               write_reg_d  = waddr;
               reg_write_d  = reg_write_in;
               hi_d         = acc[2*DATA_W-1:DATA_W];
               lo_d         = acc[DATA_W-1:0];
               whilo_d      = 1'b1;
            end
`endif
            default: state_d = StIdle;
         endcase
      end
   end

   // Gated by rstn so every output reads 0 while reset is held, even with a divide presented.
   assign stall_req = stall_c & rstn;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         rem_q        <= '0;
         quot_q       <= '0;
         dvsr_q       <= '0;
         neg_quot_q   <= 1'b0;
         neg_rem_q    <= 1'b0;
         div_waddr_q  <= '0;
         div_rw_q     <= 1'b0;
`ifdef EXE_MADD_EN
         prod_q       <= '0;
         msub_q       <= 1'b0;
`endif
         out_valid_q  <= 1'b0;
         alu_result_q <= '0;
         write_reg_q  <= '0;
         reg_write_q  <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
         whilo_q      <= 1'b0;
         ov_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rem_q        <= rem_d;
         quot_q       <= quot_d;
         dvsr_q       <= dvsr_d;
         neg_quot_q   <= neg_quot_d;
         neg_rem_q    <= neg_rem_d;
         div_waddr_q  <= div_waddr_d;
         div_rw_q     <= div_rw_d;
`ifdef EXE_MADD_EN
         prod_q       <= prod_d;
         msub_q       <= msub_d;
`endif
         out_valid_q  <= out_valid_d;
         alu_result_q <= alu_result_d;
         write_reg_q  <= write_reg_d;
         reg_write_q  <= reg_write_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         whilo_q      <= whilo_d;
         ov_q         <= ov_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign alu_result    = alu_result_q;
   assign write_reg     = write_reg_q;
   assign reg_write_out = reg_write_q;
   assign hi_out        = hi_q;
   assign lo_out        = lo_q;
   assign whilo_out     = whilo_q;
   assign ov_exc        = ov_q;

endmodule
